// File: rtl/block_pkg.sv
// Shared brick-field definitions: block codes, command codes and cell index width.
// Used by block_memory and by the collision resolver that feeds it.
package block_pkg;

  localparam int RC_W = 5;

  localparam logic [2:0] BLK_EMPTY = 3'd0;
  localparam logic [2:0] BLK_HARD  = 3'd7;

  localparam logic [1:0] FUNC_CLEAR = 2'd0;
  localparam logic [1:0] FUNC_LOAD  = 2'd1;
  localparam logic [1:0] FUNC_DROP  = 2'd2;
  localparam logic [1:0] FUNC_3     = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAITMEM,
    S_ADDR,
    S_EVAL,
    S_CLR1,
    S_WB1,
    S_CLR2,
    S_WB2,
    S_DONE
  } coll_state_t;

endpackage

// File: rtl/block_cell_map.sv
// Maps a signed pixel coordinate onto a brick cell (row, col) plus a validity flag.
// Cells left of / above the field or beyond its last row/column are invalid and index 0.
module block_cell_map
  import block_pkg::*;
#(
  parameter int FIELD_X0 = 32,
  parameter int FIELD_Y0 = 48,
  parameter int BW_LOG2  = 5,
  parameter int BH_LOG2  = 4,
  parameter int NUM_COLS = 18,
  parameter int NUM_ROWS = 12
) (
  input  logic signed [10:0] px,
  input  logic signed [10:0] py,
  output logic [RC_W-1:0]    row,
  output logic [RC_W-1:0]    col,
  output logic               valid
);

  logic signed [10:0] dx, dy;
  logic [9:0]         qx, qy;

  always_comb begin
    dx    = px - 11'(FIELD_X0);
    dy    = py - 11'(FIELD_Y0);
    qx    = dx[9:0] >> BW_LOG2;
    qy    = dy[9:0] >> BH_LOG2;
    // The sign bit rejects coordinates left of or above the field before the shift.
    valid = !dx[10] && !dy[10] && (qx < 10'(NUM_COLS)) && (qy < 10'(NUM_ROWS));
    row   = valid ? qy[RC_W-1:0] : '0;
    col   = valid ? qx[RC_W-1:0] : '0;
  end

endmodule

// File: rtl/block_collision.sv
// Per-step ball/brick resolver: probes the two leading-edge cells, clears destructible
// hits through block_memory and reports bounce flags and score for the step.
module block_collision
  import block_pkg::*;
#(
  parameter int         FIELD_X0  = 32,
  parameter int         FIELD_Y0  = 48,
  parameter int         BW_LOG2   = 5,
  parameter int         BH_LOG2   = 4,
  parameter int         NUM_COLS  = 18,
  parameter int         NUM_ROWS  = 12,
  parameter int         BALL_R    = 4,
  parameter int         READ_LAT  = 1,
  parameter logic [2:0] HARD_TYPE = BLK_HARD
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [9:0]      ball_x,
  input  logic [9:0]      ball_y,
  input  logic            dir_x,
  input  logic            dir_y,
  input  logic            mem_busy,
  input  logic [2:0]      mem_block1,
  input  logic [2:0]      mem_block2,
  output logic            mem_enable,
  output logic [1:0]      mem_func,
  output logic [RC_W-1:0] mem_row1,
  output logic [RC_W-1:0] mem_col1,
  output logic [RC_W-1:0] mem_row2,
  output logic [RC_W-1:0] mem_col2,
  output logic            busy,
  output logic            done,
  output logic            hit_x,
  output logic            hit_y,
  output logic [3:0]      score_add,
  output logic [3:0]      fsm_state
);

  coll_state_t        state;
  logic [9:0]         lx, ly;
  logic               ldx, ldy;
  logic [10:0]        bx, by;
  logic signed [10:0] p1x, p1y, p2x, p2y;
  logic [RC_W-1:0]    r1, c1, r2, c2;
  logic               v1, v2, pv1, pv2;
  logic [3:0]         lat_cnt;
  logic [2:0]         blk2_q;
  logic               clr2_q;
  logic               hit1, hit2, same_cell, clr1, clr2;

  assign fsm_state = state;
  assign mem_func  = FUNC_CLEAR;

  always_comb begin
    bx  = {1'b0, lx};
    by  = {1'b0, ly};
    p1x = ldx ? bx + 11'(BALL_R) : bx - 11'(BALL_R);
    p1y = by;
    p2x = bx;
    p2y = ldy ? by + 11'(BALL_R) : by - 11'(BALL_R);
  end

  block_cell_map #(
    .FIELD_X0(FIELD_X0), .FIELD_Y0(FIELD_Y0), .BW_LOG2(BW_LOG2),
    .BH_LOG2(BH_LOG2), .NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS)
  ) u_map1 (.px(p1x), .py(p1y), .row(r1), .col(c1), .valid(v1));

  block_cell_map #(
    .FIELD_X0(FIELD_X0), .FIELD_Y0(FIELD_Y0), .BW_LOG2(BW_LOG2),
    .BH_LOG2(BH_LOG2), .NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS)
  ) u_map2 (.px(p2x), .py(p2y), .row(r2), .col(c2), .valid(v2));

  // Evaluated only in EVAL, while both probe addresses still sit on row1/col1 and row2/col2.
  always_comb begin
    hit1      = pv1 && (mem_block1 != BLK_EMPTY);
    hit2      = pv2 && (mem_block2 != BLK_EMPTY);
    same_cell = pv1 && pv2 && (mem_row1 == mem_row2) && (mem_col1 == mem_col2);
    clr1      = hit1 && (mem_block1 != HARD_TYPE);
    clr2      = hit2 && !same_cell && (mem_block2 != HARD_TYPE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_enable <= 1'b0;
      mem_row1   <= '0;
      mem_col1   <= '0;
      mem_row2   <= '0;
      mem_col2   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit_x      <= 1'b0;
      hit_y      <= 1'b0;
      score_add  <= '0;
      lx         <= '0;
      ly         <= '0;
      ldx        <= 1'b0;
      ldy        <= 1'b0;
      pv1        <= 1'b0;
      pv2        <= 1'b0;
      lat_cnt    <= '0;
      blk2_q     <= '0;
      clr2_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          lx        <= ball_x;
          ly        <= ball_y;
          ldx       <= dir_x;
          ldy       <= dir_y;
          busy      <= 1'b1;
          hit_x     <= 1'b0;
          hit_y     <= 1'b0;
          score_add <= '0;
          state     <= S_WAITMEM;
        end
        S_WAITMEM: if (!mem_busy) begin
          mem_row1 <= r1;
          mem_col1 <= c1;
          mem_row2 <= r2;
          mem_col2 <= c2;
          pv1      <= v1;
          pv2      <= v2;
          lat_cnt  <= 4'd1;
          state    <= S_ADDR;
        end
        S_ADDR: begin
          if (lat_cnt >= 4'(READ_LAT)) state <= S_EVAL;
          else lat_cnt <= lat_cnt + 4'd1;
        end
        S_EVAL: begin
          hit_x  <= hit1;
          hit_y  <= hit2 || (same_cell && hit1);
          blk2_q <= mem_block2;
          clr2_q <= clr2;
          if (clr1) begin
            mem_enable <= 1'b1;
            score_add  <= score_add + {1'b0, mem_block1};
            state      <= S_CLR1;
          end else if (clr2) begin
            mem_row1   <= mem_row2;
            mem_col1   <= mem_col2;
            mem_enable <= 1'b1;
            score_add  <= score_add + {1'b0, mem_block2};
            state      <= S_CLR2;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_CLR1: begin
          mem_enable <= 1'b0;
          state      <= S_WB1;
        end
        S_WB1: if (!mem_busy) begin
          if (clr2_q) begin
            mem_row1   <= mem_row2;
            mem_col1   <= mem_col2;
            mem_enable <= 1'b1;
            score_add  <= score_add + {1'b0, blk2_q};
            state      <= S_CLR2;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_CLR2: begin
          mem_enable <= 1'b0;
          state      <= S_WB2;
        end
        S_WB2: if (!mem_busy) begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_collision.sv
// Directed bench for block_collision with a small block_memory stand-in
// (1-cycle read, 3-cycle busy after each clear strobe).
module tb_block_collision;
  import block_pkg::*;

  logic       clock = 1'b0;
  logic       reset, start, dir_x, dir_y, mem_busy;
  logic [9:0] ball_x, ball_y;
  logic [2:0] mem_block1, mem_block2;
  logic       mem_enable, busy, done, hit_x, hit_y;
  logic [1:0] mem_func;
  logic [4:0] mem_row1, mem_col1, mem_row2, mem_col2;
  logic [3:0] score_add, fsm_state;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic [11:0] sb_obs, sb_exp;

  logic [2:0] mem [0:31][0:31];
  logic       busy_force;
  int         clr_cnt = 0;

  int   d_cyc, d_cnt;
  logic d_seen, d_hx, d_hy;
  logic [3:0] d_sc;
  logic bad;

  block_collision dut (
    .clock(clock), .reset(reset), .start(start), .ball_x(ball_x), .ball_y(ball_y),
    .dir_x(dir_x), .dir_y(dir_y), .mem_busy(mem_busy), .mem_block1(mem_block1),
    .mem_block2(mem_block2), .mem_enable(mem_enable), .mem_func(mem_func),
    .mem_row1(mem_row1), .mem_col1(mem_col1), .mem_row2(mem_row2), .mem_col2(mem_col2),
    .busy(busy), .done(done), .hit_x(hit_x), .hit_y(hit_y), .score_add(score_add),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // memory stand-in
  assign mem_busy = busy_force | (clr_cnt != 0);

  always @(posedge clock) begin
    mem_block1 <= mem[mem_row1][mem_col1];
    mem_block2 <= mem[mem_row2][mem_col2];
    if (mem_enable) clr_cnt <= 3;
    else if (clr_cnt != 0) clr_cnt <= clr_cnt - 1;
  end

  // strobe scoreboard: {func, row1, col1} per enabled cycle
  always @(negedge clock) begin
    if (mem_enable) begin
      checks++;
      sb_obs = {mem_func, mem_row1, mem_col1};
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL strobe_unexpected observed=%h expected=none", sb_obs);
      end else begin
        sb_exp = exp_q.pop_front();
        assert (sb_obs === sb_exp) else begin
          failures++;
          $error("FAIL strobe observed=%h expected=%h", sb_obs, sb_exp);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cell(input int r, input int c, input logic [2:0] v);
    mem[r][c] = v;
  endtask

  task automatic launch(input logic [9:0] x, input logic [9:0] y, input logic dxi, input logic dyi);
    @(negedge clock);
    ball_x = x; ball_y = y; dir_x = dxi; dir_y = dyi; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_finish();
    d_cyc = 1;
    while (!done && d_cyc < 300) begin
      @(negedge clock);
      d_cyc++;
    end
    d_seen = done; d_hx = hit_x; d_hy = hit_y; d_sc = score_add;
    d_cnt = done ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) d_cnt++;
    end
  endtask

  task automatic expect_step(input string tag, input logic hx, input logic hy, input logic [3:0] sc);
    chk({tag, "_done"}, d_seen, 1);
    chk({tag, "_hit_x"}, d_hx, hx);
    chk({tag, "_hit_y"}, d_hy, hy);
    chk({tag, "_score"}, d_sc, sc);
    chk({tag, "_done_count"}, d_cnt, 1);
    chk({tag, "_hold"}, {hit_x, hit_y, score_add}, {hx, hy, sc});
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_strobes_left"}, exp_q.size(), 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) mem[r][c] = 3'd0;
    reset = 1'b1; start = 1'b0; busy_force = 1'b0;
    ball_x = '0; ball_y = '0; dir_x = 1'b0; dir_y = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_state", fsm_state, S_IDLE);
    chk("rst_outs", {mem_enable, mem_func, busy, done, hit_x, hit_y, score_add}, 0);
    chk("rst_addr", {mem_row1, mem_col1, mem_row2, mem_col2}, 0);
    reset = 1'b0;

    // same cell row0/col2, code 3
    set_cell(0, 2, 3'd3);
    exp_q.push_back({2'd0, 5'd0, 5'd2});
    launch(10'd100, 10'd60, 1'b1, 1'b0);
    chk("t1_busy", busy, 1);
    wait_finish();
    expect_step("t1", 1, 1, 4'd3);

    // two distinct cells row1/col3 (2) then row2/col3 (5)
    set_cell(1, 3, 3'd2); set_cell(2, 3, 3'd5);
    exp_q.push_back({2'd0, 5'd1, 5'd3});
    exp_q.push_back({2'd0, 5'd2, 5'd3});
    launch(10'd128, 10'd76, 1'b1, 1'b1);
    wait_finish();
    expect_step("t2", 1, 1, 4'd7);

    // hard block in the shared cell: bounce, no clear
    set_cell(0, 2, 3'd7);
    launch(10'd100, 10'd60, 1'b1, 1'b0);
    wait_finish();
    expect_step("hard", 1, 1, 4'd0);

    // only the vertical probe hits: P1 row0/col2 empty, P2 row1/col2 = 4
    set_cell(0, 2, 3'd0); set_cell(1, 2, 3'd4);
    exp_q.push_back({2'd0, 5'd1, 5'd2});
    launch(10'd100, 10'd60, 1'b0, 1'b1);
    wait_finish();
    expect_step("vert", 0, 1, 4'd4);

    // right edge: P1 x=608 is column 18 (invalid), P2 lands on column 17
    set_cell(0, 17, 3'd1);
    exp_q.push_back({2'd0, 5'd0, 5'd17});
    launch(10'd604, 10'd52, 1'b1, 1'b0);
    wait_finish();
    expect_step("edge", 0, 1, 4'd1);

    // outside the field entirely
    launch(10'd20, 10'd30, 1'b1, 1'b1);
    wait_finish();
    expect_step("out", 0, 0, 4'd0);
    chk("out_latency_le4", d_cyc <= 4, 1);
    chk("out_addr_zero", {mem_row1, mem_col1, mem_row2, mem_col2}, 0);

    // busy interlock with a second start during the hold
    set_cell(1, 3, 3'd1); set_cell(2, 3, 3'd1);
    busy_force = 1'b1;
    launch(10'd128, 10'd76, 1'b1, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin ball_x = 10'd100; ball_y = 10'd60; start = 1'b1; end
      if (i == 11) start = 1'b0;
      @(negedge clock);
      if (mem_enable || done || !busy || fsm_state != S_WAITMEM ||
          mem_row1 != 0 || mem_col1 != 0 || mem_row2 != 0 || mem_col2 != 0) bad = 1'b1;
    end
    chk("lock_hold", bad, 0);
    exp_q.push_back({2'd0, 5'd1, 5'd3});
    exp_q.push_back({2'd0, 5'd2, 5'd3});
    busy_force = 1'b0;
    wait_finish();
    expect_step("lock", 1, 1, 4'd2);

    // reset while waiting for the first clear to finish
    set_cell(0, 2, 3'd3);
    exp_q.push_back({2'd0, 5'd0, 5'd2});
    launch(10'd100, 10'd60, 1'b1, 1'b0);
    d_cyc = 0;
    while (fsm_state != S_WB1 && d_cyc < 50) begin
      @(negedge clock);
      d_cyc++;
    end
    chk("rmid_reached_wb1", fsm_state, S_WB1);
    reset = 1'b1;
    @(negedge clock);
    chk("rmid_outs", {mem_enable, busy, done}, 0);
    chk("rmid_state", fsm_state, S_IDLE);
    reset = 1'b0;
    d_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done || mem_enable) d_cnt++;
    end
    chk("rmid_quiet", d_cnt, 0);

    // fresh step after the reset
    set_cell(1, 3, 3'd6);
    exp_q.push_back({2'd0, 5'd1, 5'd3});
    launch(10'd128, 10'd76, 1'b1, 1'b0);
    wait_finish();
    expect_step("fresh", 1, 1, 4'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
